// File: rtl/shift_rows.sv
`default_nettype none
// ============================================================================
// Module   : shift_rows
// Purpose  : AES ShiftRows round stage, 1-cycle registered byte permutation.
//            Optional InvShiftRows selected by inv_mode when the macro
//            SHIFT_ROWS_INV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module shift_rows #(
    parameter int DATA_LEN = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [DATA_LEN-1:0] data_in,
`ifdef SHIFT_ROWS_INV_EN
    input  logic                inv_mode,
`endif
    output logic                valid_out,
    output logic [DATA_LEN-1:0] data_out
);

    generate
        if (DATA_LEN != 128) begin : g_bad_len
            $error("shift_rows: DATA_LEN must be 128");
        end
    endgenerate

    logic [DATA_LEN-1:0] w_fwd;
    logic [DATA_LEN-1:0] w_next;
    logic                r_valid;
    logic [DATA_LEN-1:0] r_data;

    // Byte k sits at bits [127-8k -: 8]; state is column-major, byte = 4c + r.
    generate
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                localparam int c_DST     = 4 * c + r;
                localparam int c_FWD_SRC = 4 * ((c + r) % 4) + r;
                assign w_fwd[DATA_LEN-1-8*c_DST -: 8] = data_in[DATA_LEN-1-8*c_FWD_SRC -: 8];
            end
        end
    endgenerate

`ifdef SHIFT_ROWS_INV_EN
    logic [DATA_LEN-1:0] w_inv;

    generate
        for (genvar c = 0; c < 4; c++) begin : g_inv_col
            for (genvar r = 0; r < 4; r++) begin : g_inv_row
                localparam int c_DST     = 4 * c + r;
                localparam int c_INV_SRC = 4 * ((c - r + 4) % 4) + r;
                assign w_inv[DATA_LEN-1-8*c_DST -: 8] = data_in[DATA_LEN-1-8*c_INV_SRC -: 8];
            end
        end
    endgenerate

    assign w_next = inv_mode ? w_inv : w_fwd;
`else
    assign w_next = w_fwd;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_data <= w_next;
            end
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_rows.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rows
// Purpose  : Scoreboard testbench for shift_rows (directed + random beats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rows;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [127:0] data_in;
    logic         inv_mode;
    logic         valid_out;
    logic [127:0] data_out;

    logic [127:0] exp_q[$];
    logic [127:0] exp_hold;
    int           n_checks = 0;
    int           n_pass   = 0;

    shift_rows #(.DATA_LEN(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
`ifdef SHIFT_ROWS_INV_EN
        .inv_mode  (inv_mode),
`endif
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // Reference: out[r][c] = in[r][(c +/- r) mod 4], column-major byte order.
    function automatic logic [127:0] ref_sr(input logic [127:0] d, input logic inv);
        logic [7:0]   b[16];
        logic [127:0] o;
        int           src;
        o = '0;
        for (int k = 0; k < 16; k++) b[k] = d[127-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = b[4*src + r];
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one beat; push either a supplied expectation or the model's.
    task automatic drive(input logic v, input logic [127:0] d, input logic inv,
                         input bit use_exp, input logic [127:0] exp);
        @(posedge clk);
        #1;
        valid_in = v;
        data_in  = d;
        inv_mode = inv;
        if (v && reset) exp_q.push_back(use_exp ? exp : ref_sr(d, inv));
    endtask

    function automatic logic rand_inv();
`ifdef SHIFT_ROWS_INV_EN
        return logic'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops on every valid_out, otherwise checks idle/hold behaviour.
    initial begin : monitor
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: got valid_out=1 data_out=%h expected no output", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", data_out, e);
                    exp_hold = e;
                end
            end else begin
                chk("valid_out_idle", {127'b0, valid_out}, 128'b0);
                chk("data_hold", data_out, exp_hold);
            end
        end
    end

    initial begin : stim
        logic [127:0] v1, v2, v1_out, v2_out;
        v1     = 128'h0123456789ABCDEFFEDCBA9876543210;
        v1_out = 128'h01ABBA1089DC3267FE5445EF7623CD98;
        v2     = 128'h00112233445566778899AABBCCDDEEFF;
        v2_out = 128'h0055AAFF4499EE3388DD2277CC1166BB;

        exp_hold = '0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        inv_mode = 1'b0;
        #1 reset = 1'b0;

        // valid_in toggling under reset must produce nothing
        for (int i = 0; i < 4; i++) drive(logic'(i % 2 == 0), rand128(), 1'b0, 1'b0, '0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Directed vectors, back-to-back, then hold
        drive(1'b1, v1, 1'b0, 1'b1, v1_out);
        drive(1'b1, v2, 1'b0, 1'b1, v2_out);
        drive(1'b0, rand128(), 1'b0, 1'b0, '0);
        drive(1'b0, rand128(), 1'b0, 1'b0, '0);
`ifdef SHIFT_ROWS_INV_EN
        drive(1'b1, v2_out, 1'b1, 1'b1, v2);
        drive(1'b1, v1, 1'b0, 1'b1, v1_out);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
`endif

        // Random traffic
        for (int i = 0; i < 300; i++)
            drive(logic'($urandom_range(0, 3) != 0), rand128(), rand_inv(), 1'b0, '0);

        // Mid-stream reset: the beat presented during reset must vanish
        drive(1'b1, rand128() | 128'h1, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        data_in  = rand128();
        @(negedge clk);
        #1;
        exp_hold = '0;
        reset    = 1'b0;
        #1;
        chk("reset_async_valid", {127'b0, valid_out}, 128'b0);
        chk("reset_async_data", data_out, 128'b0);
        repeat (2) @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) drive(1'b0, rand128(), 1'b0, 1'b0, '0);

        // First capture after reset release
        drive(1'b1, v1, 1'b0, 1'b1, v1_out);
        drive(1'b0, '0, 1'b0, 1'b0, '0);

        // Bounded drain
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d outstanding beats expected 0", exp_q.size());
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
